alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 32-bit ALU (add, sub, and, or) between `NREQ` requesters. Each requester presents operands and an op code with a valid/ready handshake. The block grants one requester per cycle, evaluates the ALU, and captures the result in a one-entry output register tagged with the requester ID. It sits between the requesting units (e.g. address-generation and execute stages) and a single shared `alu` instance that it contains.

---
 rtl/alu_share_arbiter.sv | 102 ++++++++++
 tb/tb_alu_share_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one 32-bit add/sub/and/or ALU between NREQ
// requesters and registers the winner's result in a one-entry tagged slot.

module alu (
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    always_comb begin
        case (op)
            2'b00:   y = a + b;
            2'b01:   y = a + ~b + 32'd1;
            2'b10:   y = a & b;
            default: y = a | b;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_reqValid,
    input  logic [NREQ*32-1:0]   i_reqA,
    input  logic [NREQ*32-1:0]   i_reqB,
    input  logic [NREQ*2-1:0]    i_reqOp,
    output logic [NREQ-1:0]      o_reqReady,
    output logic                 o_rspValid,
    output logic [IDW-1:0]       o_rspId,
    output logic [31:0]          o_rspResult,
    input  logic                 i_rspReady
);
    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t           reqs [NREQ];
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] sel_id;
    logic           any;
    logic [NREQ-1:0] cand;
    logic           slot_free;
    logic           accept;
    logic [31:0]    alu_y;

    for (genvar k = 0; k < NREQ; k++) begin : g_req
        assign reqs[k] = '{op: i_reqOp[2*k +: 2], a: i_reqA[32*k +: 32], b: i_reqB[32*k +: 32]};
    end

    // Scan from the far end toward ptr so the nearest valid requester wins last.
    always_comb begin
        int j;
        j      = 0;
        sel_id = '0;
        any    = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (i_reqValid[j]) begin
                sel_id = IDW'(j);
                any    = 1'b1;
            end
        end
    end

    always_comb begin
        cand = '0;
        if (any) cand[sel_id] = 1'b1;
    end

    assign slot_free  = ~o_rspValid | i_rspReady;
    assign accept     = any & slot_free;
    assign o_reqReady = (i_rst_n & slot_free) ? cand : '0;

    alu u_alu (
        .op (reqs[sel_id].op),
        .a  (reqs[sel_id].a),
        .b  (reqs[sel_id].b),
        .y  (alu_y)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr         <= '0;
            o_rspValid  <= 1'b0;
            o_rspId     <= '0;
            o_rspResult <= '0;
        end else if (accept) begin
            o_rspValid  <= 1'b1;
            o_rspId     <= sel_id;
            o_rspResult <= alu_y;
            ptr         <= (sel_id == IDW'(NREQ - 1)) ? '0 : sel_id + IDW'(1);
        end else if (i_rspReady) begin
            o_rspValid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: stimulus pushes hand-computed results into a scoreboard,
// a monitor pops and compares whenever the DUT hands off a result.

module tb_alu_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    res;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*2-1:0]    req_op;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_result;
    logic                 rsp_ready;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_reqValid  (req_valid),
        .i_reqA      (req_a),
        .i_reqB      (req_b),
        .i_reqOp     (req_op),
        .o_reqReady  (req_ready),
        .o_rspValid  (rsp_valid),
        .o_rspId     (rsp_id),
        .o_rspResult (rsp_result),
        .i_rspReady  (rsp_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*k +: 2] = op;
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
    endtask

    // One cycle: check ready at the negedge, queue the expected result on a grant.
    task automatic tick(input string name, input logic [NREQ-1:0] exp_rdy, input logic [31:0] exp_res);
        rsp_t e;
        @(negedge clk);
        chk({name, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            e.id = '0;
            for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) e.id = IDW'(i);
            e.res = exp_res;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: every consumed result must match the oldest queued expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon.unexpected: got id=%0d res=0x%08h expected no response", rsp_id, rsp_result);
            end else begin
                e = sb.pop_front();
                chk("mon.id", 32'(rsp_id), 32'(e.id));
                chk("mon.res", rsp_result, e.res);
            end
        end
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '1;
        req_a = '0; req_b = '0; req_op = '0;
        for (int k = 0; k < NREQ; k++) set_req(k, 2'(k), 32'hF0F0_F0F0, 32'h0FF0_0FF0);

        // Reset held two cycles with everyone requesting.
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'h0);
        chk("rst.valid", 32'(rsp_valid), 32'h0);
        chk("rst.id", 32'(rsp_id), 32'h0);
        chk("rst.res", rsp_result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full contention: 0,1,2,3,0.
        tick("cont0", 4'b0001, 32'h00E1_00E0);
        tick("cont1", 4'b0010, 32'hE100_E100);
        tick("cont2", 4'b0100, 32'h00F0_00F0);
        tick("cont3", 4'b1000, 32'hFFF0_FFF0);
        tick("cont4", 4'b0001, 32'h00E1_00E0);

        // Single sub, ptr=1.
        req_valid = 4'b0010; set_req(1, 2'b01, 32'd5, 32'd7);
        tick("sub", 4'b0010, 32'hFFFF_FFFE);
        req_valid = 4'b0000;
        tick("idle", 4'b0000, 32'h0);

        // Backpressure: ptr=2, grant 3, then stall three cycles.
        req_valid = 4'b1000; set_req(3, 2'b00, 32'd1, 32'd2);
        tick("bp.grant", 4'b1000, 32'd3);
        rsp_ready = 1'b0; req_valid = 4'b0111;
        set_req(0, 2'b00, 32'd10, 32'd20);
        for (int c = 0; c < 3; c++) begin
            tick("bp.stall", 4'b0000, 32'h0);
            chk("bp.valid", 32'(rsp_valid), 32'h1);
            chk("bp.id", 32'(rsp_id), 32'd3);
            chk("bp.res", rsp_result, 32'd3);
        end
        rsp_ready = 1'b1;
        tick("bp.release", 4'b0001, 32'd30);

        // Wrap/skip: ptr=1, grant 2 -> ptr=3, then {0,2} -> 0, then 2.
        req_valid = 4'b0100; set_req(2, 2'b11, 32'h1, 32'h2);
        tick("wrap.g2", 4'b0100, 32'd3);
        req_valid = 4'b0101; set_req(0, 2'b01, 32'd100, 32'd1);
        tick("wrap.g0", 4'b0001, 32'd99);
        tick("wrap.g2b", 4'b0100, 32'd3);

        // Reset mid-operation with an unconsumed result pending.
        req_valid = 4'b1000; set_req(3, 2'b10, 32'hFF, 32'h0F);
        tick("mid.grant", 4'b1000, 32'h0F);
        rsp_ready = 1'b0; req_valid = 4'b1111;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid.rst_ready", 32'(req_ready), 32'h0);
        chk("mid.pending", 32'(rsp_valid), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid.valid", 32'(rsp_valid), 32'h0);
        chk("mid.id", 32'(rsp_id), 32'h0);
        chk("mid.res", rsp_result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1100;
        tick("mid.g2", 4'b0100, 32'd3);
        tick("mid.g3", 4'b1000, 32'h0F);
        req_valid = 4'b0000;
        tick("tail0", 4'b0000, 32'h0);
        tick("tail1", 4'b0000, 32'h0);
        chk("sb.empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
